gsram_dp_ctrl: RTL and testbench

Controller that sits directly upstream of the GSRAM_8192x2 dual-port macro wrapper and owns both of its ports. It clears the array after reset or on request. It then arbitrates two independent client channels (valid/ready request, valid/ready response) onto ports 0/1. Read data returns through per-channel 2-entry response FIFOs so clients may backpressure.

---
 rtl/gsram_dp_ctrl_if.sv | 45 ++++
 rtl/gsram_dp_ctrl.sv | 176 +++++++++++++++++
 tb/tb_gsram_dp_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsram_dp_ctrl_if.sv
// Client-channel and SRAM-port bundle for gsram_dp_ctrl.
// slave = controller view; master = clients plus the SRAM macro.
interface gsram_dp_ctrl_if #(
    parameter int ABITS = 13,
    parameter int DBITS = 2
);
    logic             init_start;
    logic             init_done;

    logic             req_valid_0, req_ready_0, req_we_0;
    logic [ABITS-1:0] req_addr_0;
    logic [DBITS-1:0] req_data_0;
    logic             req_valid_1, req_ready_1, req_we_1;
    logic [ABITS-1:0] req_addr_1;
    logic [DBITS-1:0] req_data_1;

    logic             rsp_valid_0, rsp_ready_0;
    logic [DBITS-1:0] rsp_data_0;
    logic             rsp_valid_1, rsp_ready_1;
    logic [DBITS-1:0] rsp_data_1;

    logic [ABITS-1:0] A0, A1;
    logic [DBITS-1:0] D0, D1, WEM0, WEM1, Q0, Q1;
    logic             WE0, WE1, CE0, CE1;

    modport slave (
        input  init_start,
        input  req_valid_0, req_we_0, req_addr_0, req_data_0,
        input  req_valid_1, req_we_1, req_addr_1, req_data_1,
        input  rsp_ready_0, rsp_ready_1, Q0, Q1,
        output init_done, req_ready_0, req_ready_1,
        output rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1,
        output A0, A1, D0, D1, WE0, WE1, WEM0, WEM1, CE0, CE1
    );

    modport master (
        output init_start,
        output req_valid_0, req_we_0, req_addr_0, req_data_0,
        output req_valid_1, req_we_1, req_addr_1, req_data_1,
        output rsp_ready_0, rsp_ready_1, Q0, Q1,
        input  init_done, req_ready_0, req_ready_1,
        input  rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1,
        input  A0, A1, D0, D1, WE0, WE1, WEM0, WEM1, CE0, CE1
    );
endinterface

// File: rtl/gsram_dp_ctrl.sv
// Dual-port GSRAM controller: clear sweep, two client channels mapped to ports 0/1,
// 2-entry per-channel read-response FIFOs with empty-FIFO bypass of the SRAM output.
module gsram_dp_ctrl #(
    parameter int ABITS         = 13,
    parameter int DBITS         = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic           CLK,
    input  logic           RSTN,
    gsram_dp_ctrl_if.slave bus
);
    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
    localparam state_t           RESET_STATE = INIT_ON_RESET ? ST_CLEAR : ST_READY;
    localparam logic [ABITS-2:0] K_ONE       = 1;

    state_t           state_q, state_d;
    logic [ABITS-2:0] k_q, k_d;
    logic             init_go;
    logic             collide;
    logic [1:0]       fifo_empty, rd_busy;

    logic             req_valid [2];
    logic             req_we    [2];
    logic [ABITS-1:0] req_addr  [2];
    logic [DBITS-1:0] req_data  [2];
    logic             rsp_ready [2];
    logic [DBITS-1:0] q_in      [2];
    logic             ready_o   [2];
    logic             rsp_valid_o [2];
    logic [DBITS-1:0] rsp_data_o  [2];
    logic             ce_o [2];
    logic             we_o [2];
    logic [ABITS-1:0] a_o  [2];
    logic [DBITS-1:0] d_o  [2];

    assign req_valid[0] = bus.req_valid_0;  assign req_valid[1] = bus.req_valid_1;
    assign req_we[0]    = bus.req_we_0;     assign req_we[1]    = bus.req_we_1;
    assign req_addr[0]  = bus.req_addr_0;   assign req_addr[1]  = bus.req_addr_1;
    assign req_data[0]  = bus.req_data_0;   assign req_data[1]  = bus.req_data_1;
    assign rsp_ready[0] = bus.rsp_ready_0;  assign rsp_ready[1] = bus.rsp_ready_1;
    assign q_in[0]      = bus.Q0;           assign q_in[1]      = bus.Q1;

    // Same-address conflict involving a write: channel 0 wins, channel 1 retries.
    assign collide = req_valid[0] && req_valid[1] && (req_addr[0] == req_addr[1])
                     && (req_we[0] || req_we[1]);

    assign bus.init_done = RSTN && (state_q == ST_READY);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        init_go = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                k_d = k_q + K_ONE;
                if (&k_q) state_d = ST_READY;
            end
            default: begin
                if (bus.init_start && (&fifo_empty) && (rd_busy == 2'b00)) begin
                    init_go = 1'b1;
                    state_d = ST_CLEAR;
                    k_d     = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= RESET_STATE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic             read_ok, blocked, fire;
        logic             ce, we;
        logic [ABITS-1:0] a_q, a_d;
        logic [DBITS-1:0] d_q, d_d;
        logic             infl_q, infl_d;
        logic             push, pop, rsp_valid;
        logic [DBITS-1:0] mem_q [2];
        logic [DBITS-1:0] mem_d [2];
        logic             wr_q, wr_d, rd_q, rd_d;
        logic [1:0]       cnt_q, cnt_d;

        // Reads need a guaranteed FIFO slot counting the read already at the SRAM.
        assign read_ok = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !infl_q);
        assign blocked = (gi == 1) && collide;
        assign ready_o[gi] = RSTN && (state_q == ST_READY) && !init_go
                             && (req_we[gi] || read_ok) && !blocked;
        assign fire = req_valid[gi] && ready_o[gi];

        always_comb begin
            ce  = 1'b0;
            we  = 1'b0;
            a_d = a_q;
            d_d = d_q;
            if (state_q == ST_CLEAR) begin
                ce  = 1'b1;
                we  = 1'b1;
                a_d = {k_q, 1'(gi)};
                d_d = '0;
            end else if (fire) begin
                ce  = 1'b1;
                we  = req_we[gi];
                a_d = req_addr[gi];
                if (req_we[gi]) d_d = req_data[gi];
            end
        end

        assign ce_o[gi] = RSTN && ce;
        assign we_o[gi] = RSTN && we;
        assign a_o[gi]  = RSTN ? a_d : '0;
        assign d_o[gi]  = RSTN ? d_d : '0;

        // SRAM data lands one cycle after issue; with an empty FIFO it is the head directly.
        assign infl_d          = fire && !req_we[gi];
        assign push            = infl_q;
        assign rsp_valid       = (cnt_q != 2'd0) || infl_q;
        assign pop             = rsp_valid && rsp_ready[gi];
        assign rsp_valid_o[gi] = rsp_valid;
        assign rsp_data_o[gi]  = (cnt_q != 2'd0) ? mem_q[rd_q] : (infl_q ? q_in[gi] : '0);
        assign fifo_empty[gi]  = (cnt_q == 2'd0);
        assign rd_busy[gi]     = infl_q;

        always_comb begin
            mem_d = mem_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push) begin
                mem_d[wr_q] = q_in[gi];
                wr_d        = !wr_q;
            end
            if (pop) rd_d = !rd_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                a_q    <= '0;
                d_q    <= '0;
                infl_q <= 1'b0;
                wr_q   <= 1'b0;
                rd_q   <= 1'b0;
                cnt_q  <= 2'd0;
                for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            end else begin
                a_q    <= a_d;
                d_q    <= d_d;
                infl_q <= infl_d;
                wr_q   <= wr_d;
                rd_q   <= rd_d;
                cnt_q  <= cnt_d;
                mem_q  <= mem_d;
            end
        end
    end

    assign bus.req_ready_0 = ready_o[0];      assign bus.req_ready_1 = ready_o[1];
    assign bus.rsp_valid_0 = rsp_valid_o[0];  assign bus.rsp_valid_1 = rsp_valid_o[1];
    assign bus.rsp_data_0  = rsp_data_o[0];   assign bus.rsp_data_1  = rsp_data_o[1];
    assign bus.CE0  = ce_o[0];                assign bus.CE1  = ce_o[1];
    assign bus.WE0  = we_o[0];                assign bus.WE1  = we_o[1];
    assign bus.A0   = a_o[0];                 assign bus.A1   = a_o[1];
    assign bus.D0   = d_o[0];                 assign bus.D1   = d_o[1];
    assign bus.WEM0 = {DBITS{we_o[0]}};       assign bus.WEM1 = {DBITS{we_o[1]}};
endmodule

// File: tb/tb_gsram_dp_ctrl.sv
// Bench for gsram_dp_ctrl: behavioural SRAM, directed sequences, vector table,
// and randomized traffic checked against a transaction-level reference model.
module tb_gsram_dp_ctrl;
    localparam int AB = 13;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic fill_en = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gsram_dp_ctrl_if #(.ABITS(AB), .DBITS(DB)) bus ();

    gsram_dp_ctrl #(.ABITS(AB), .DBITS(DB), .INIT_ON_RESET(1'b1)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    // Behavioural dual-port macro: registered read, random power-up contents.
    logic [DB-1:0] sram [1<<AB];
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < (1<<AB); i++) sram[i] <= 2'($urandom);
            sram[13'h1ABC] <= 2'b11;
            bus.Q0 <= '0;
            bus.Q1 <= '0;
        end else begin
            if (bus.CE0 && bus.WE0) sram[bus.A0] <= bus.D0;
            if (bus.CE1 && bus.WE1) sram[bus.A1] <= bus.D1;
            if (bus.CE0 && !bus.WE0) bus.Q0 <= sram[bus.A0];
            if (bus.CE1 && !bus.WE1) bus.Q1 <= sram[bus.A1];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.req_valid_0 = v; bus.req_we_0 = we; bus.req_addr_0 = a; bus.req_data_0 = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.req_valid_1 = v; bus.req_we_1 = we; bus.req_addr_1 = a; bus.req_data_1 = d;
    endtask

    typedef struct {
        logic          v0, we0;
        logic [AB-1:0] a0;
        logic [DB-1:0] d0;
        logic          v1, we1;
        logic [AB-1:0] a1;
        logic [DB-1:0] d1;
        logic [5:0]    exp;   // {ready0, ready1, CE0, WE0, CE1, WE1}
    } vec_t;

    typedef struct {
        logic [DB-1:0] data;
        int            cyc;
    } rsp_t;

    vec_t          tbl [8];
    rsp_t          exp_q [2][$];
    logic [DB-1:0] refmem [1<<AB];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            errs;
        int            w;
        logic [DB-1:0] wv [3];

        tbl[0] = '{1'b0, 1'b0, 13'h000, 2'd0, 1'b0, 1'b0, 13'h000, 2'd0, 6'b11_00_00};
        tbl[1] = '{1'b1, 1'b1, 13'h020, 2'd1, 1'b0, 1'b0, 13'h000, 2'd0, 6'b11_11_00};
        tbl[2] = '{1'b1, 1'b0, 13'h020, 2'd0, 1'b1, 1'b0, 13'h021, 2'd0, 6'b11_10_10};
        tbl[3] = '{1'b1, 1'b1, 13'h030, 2'd2, 1'b1, 1'b1, 13'h030, 2'd3, 6'b10_11_00};
        tbl[4] = '{1'b1, 1'b0, 13'h030, 2'd0, 1'b1, 1'b0, 13'h030, 2'd0, 6'b11_10_10};
        tbl[5] = '{1'b1, 1'b0, 13'h040, 2'd0, 1'b1, 1'b1, 13'h040, 2'd1, 6'b10_10_00};
        tbl[6] = '{1'b1, 1'b1, 13'h050, 2'd3, 1'b1, 1'b1, 13'h051, 2'd2, 6'b11_11_11};
        tbl[7] = '{1'b0, 1'b1, 13'h060, 2'd1, 1'b1, 1'b1, 13'h060, 2'd2, 6'b11_00_11};

        bus.init_start = 1'b0;
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        bus.rsp_ready_0 = 1'b0;
        bus.rsp_ready_1 = 1'b0;

        // ---- Reset, then power-on clear sweep with a read waiting on channel 0
        repeat (3) @(posedge clk);
        fill_en = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.CE0, bus.CE1, bus.WE0, bus.WE1, bus.A0, bus.A1, bus.D0, bus.D1,
                              bus.init_done, bus.req_ready_0, bus.req_ready_1,
                              bus.rsp_valid_0, bus.rsp_valid_1}, 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        set0(1'b1, 1'b0, 13'h1ABC, '0);
        bus.rsp_ready_0 = 1'b1;
        errs = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            if (!(bus.CE0 && bus.CE1 && bus.WE0 && bus.WE1)) errs++;
            if (bus.A0 != 13'(2*k) || bus.A1 != 13'(2*k+1)) errs++;
            if (bus.D0 != 2'd0 || bus.D1 != 2'd0 || bus.WEM0 != 2'b11) errs++;
            if (bus.init_done || bus.req_ready_0 || bus.req_ready_1) errs++;
            cyc();
        end
        chk("clear_sweep_errors", errs, 0);
        @(negedge clk);
        chk("init_done_cycle4097", bus.init_done, 1'b1);
        chk("first_read_ready", bus.req_ready_0, 1'b1);
        cyc();
        set0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("cleared_read_valid", bus.rsp_valid_0, 1'b1);
        chk("cleared_read_data", bus.rsp_data_0, 2'b00);
        cyc();
        bus.rsp_ready_0 = 1'b0;

        // ---- Write then read on ch0, concurrent read on ch1
        set0(1'b1, 1'b1, 13'h0005, 2'b10);
        @(negedge clk);
        chk("wr5_ready", bus.req_ready_0, 1'b1);
        cyc();
        set0(1'b1, 1'b0, 13'h0005, '0);
        set1(1'b1, 1'b0, 13'h0005, '0);
        @(negedge clk);
        chk("rd5_both_ready", {bus.req_ready_0, bus.req_ready_1}, 2'b11);
        chk("rd5_no_early_rsp", bus.rsp_valid_0, 1'b0);
        cyc();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;
        @(negedge clk);
        chk("rd5_ch0_rsp", {bus.rsp_valid_0, bus.rsp_data_0}, {1'b1, 2'b10});
        chk("rd5_ch1_rsp", {bus.rsp_valid_1, bus.rsp_data_1}, {1'b1, 2'b10});
        cyc();
        @(negedge clk);
        chk("rd5_drained", {bus.rsp_valid_0, bus.rsp_valid_1}, 2'b00);
        cyc();
        bus.rsp_ready_0 = 1'b0;
        bus.rsp_ready_1 = 1'b0;

        // ---- Three back-to-back reads with a stalled consumer
        wv[0] = 2'd1; wv[1] = 2'd3; wv[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            set0(1'b1, 1'b1, 13'(13'h10 + i), wv[i]);
            cyc();
        end
        set0(1'b1, 1'b0, 13'h10, '0);
        @(negedge clk);
        chk("bp_rd1_ready", bus.req_ready_0, 1'b1);
        cyc();
        set0(1'b1, 1'b0, 13'h11, '0);
        @(negedge clk);
        chk("bp_rd2_ready", bus.req_ready_0, 1'b1);
        cyc();
        set0(1'b1, 1'b0, 13'h12, '0);
        @(negedge clk);
        chk("bp_rd3_stall", bus.req_ready_0, 1'b0);
        cyc();
        bus.rsp_ready_0 = 1'b1;
        @(negedge clk);
        chk("bp_rd3_still_stall", bus.req_ready_0, 1'b0);
        chk("bp_rsp1", {bus.rsp_valid_0, bus.rsp_data_0}, {1'b1, 2'd1});
        cyc();
        @(negedge clk);
        chk("bp_rsp2", {bus.rsp_valid_0, bus.rsp_data_0}, {1'b1, 2'd3});
        chk("bp_rd3_accepted", bus.req_ready_0, 1'b1);
        cyc();
        set0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("bp_rsp3", {bus.rsp_valid_0, bus.rsp_data_0}, {1'b1, 2'd2});
        cyc();
        @(negedge clk);
        chk("bp_empty", bus.rsp_valid_0, 1'b0);
        cyc();

        // ---- Collision: ch0 write vs ch1 read on the same address
        bus.rsp_ready_1 = 1'b1;
        set0(1'b1, 1'b1, 13'h0100, 2'b11);
        set1(1'b1, 1'b0, 13'h0100, '0);
        @(negedge clk);
        chk("coll_ready", {bus.req_ready_0, bus.req_ready_1, bus.CE1}, 3'b100);
        cyc();
        set0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("coll_retry_ready", bus.req_ready_1, 1'b1);
        cyc();
        set1(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("coll_rsp", {bus.rsp_valid_1, bus.rsp_data_1}, {1'b1, 2'b11});
        cyc();
        set0(1'b1, 1'b1, 13'h0200, 2'b01);
        set1(1'b1, 1'b0, 13'h0100, '0);
        @(negedge clk);
        chk("nocoll_both_ready", {bus.req_ready_0, bus.req_ready_1}, 2'b11);
        cyc();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("nocoll_rsp", {bus.rsp_valid_1, bus.rsp_data_1}, {1'b1, 2'b11});
        cyc();
        cyc();

        // ---- Vector table: single-cycle arbitration and port mapping
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set0(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0);
            set1(tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), {bus.req_ready_0, bus.req_ready_1, bus.CE0, bus.WE0,
                                             bus.CE1, bus.WE1}, tbl[i].exp);
            if (tbl[i].exp[3]) chk($sformatf("vec%0d_a0", i), bus.A0, tbl[i].a0);
            if (tbl[i].exp[1]) chk($sformatf("vec%0d_a1", i), bus.A1, tbl[i].a1);
            cyc();
        end
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("idle_hold_a0", {bus.CE0, bus.WE0, bus.A0}, {2'b00, 13'h050});
        repeat (3) cyc();
        bus.rsp_ready_0 = 1'b0;
        bus.rsp_ready_1 = 1'b0;

        // ---- init_start with a read in flight is ignored; idle init_start restarts the sweep
        set1(1'b1, 1'b0, 13'h0007, '0);
        @(negedge clk);
        chk("inflight_rd_ready", bus.req_ready_1, 1'b1);
        cyc();
        set1(1'b0, 1'b0, '0, '0);
        bus.init_start = 1'b1;
        cyc();
        bus.init_start = 1'b0;
        @(negedge clk);
        chk("init_ignored", {bus.init_done, bus.CE0}, 2'b10);
        bus.rsp_ready_1 = 1'b1;
        cyc();
        bus.rsp_ready_1 = 1'b0;
        cyc();
        bus.init_start = 1'b1;
        @(negedge clk);
        chk("init_accept_cycle_done", bus.init_done, 1'b1);
        cyc();
        bus.init_start = 1'b0;
        @(negedge clk);
        chk("init_started", {bus.init_done, bus.CE0, bus.WE0, bus.A0, bus.A1},
            {3'b011, 13'h0000, 13'h0001});
        repeat (1000) cyc();
        @(negedge clk);
        chk("sweep_k1000", {bus.A0, bus.A1}, {13'd2000, 13'd2001});
        #1 rstn = 1'b0;
        #1;
        chk("midsweep_reset_outputs", {bus.CE0, bus.CE1, bus.WE0, bus.WE1, bus.A0, bus.A1,
                                       bus.D0, bus.D1, bus.init_done}, 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("sweep_restart", {bus.CE0, bus.WE0, bus.A0, bus.A1}, {2'b11, 13'h0000, 13'h0001});
        w = 0;
        while (!bus.init_done && w < 5000) begin
            cyc();
            w++;
        end
        chk("sweep2_done", bus.init_done, 1'b1);
        chk("sweep2_len", w, 4096);

        // ---- Randomized traffic against the reference model
        for (int i = 0; i < (1<<AB); i++) refmem[i] = '0;
        begin
            int cyc_n = 0;
            for (int n = 0; n < 3020; n++) begin
                logic          v [2];
                logic          we [2];
                logic [AB-1:0] a [2];
                logic [DB-1:0] d [2];
                logic          rr [2];
                logic          r [2];
                logic          rv [2];
                logic [DB-1:0] rd [2];
                logic          ce [2];
                logic          weo [2];
                logic [AB-1:0] ao [2];
                logic          exp_r [2];
                logic          exp_rv [2];
                logic          coll;
                bit            drain;
                drain = (n >= 3000);
                set0(!drain && ($urandom_range(0, 3) != 0), 1'($urandom), 13'($urandom_range(0, 7)), 2'($urandom));
                set1(!drain && ($urandom_range(0, 3) != 0), 1'($urandom), 13'($urandom_range(0, 7)), 2'($urandom));
                bus.rsp_ready_0 = drain || ($urandom_range(0, 3) != 0);
                bus.rsp_ready_1 = drain || ($urandom_range(0, 3) != 0);
                @(negedge clk);
                v[0] = bus.req_valid_0; we[0] = bus.req_we_0; a[0] = bus.req_addr_0; d[0] = bus.req_data_0;
                v[1] = bus.req_valid_1; we[1] = bus.req_we_1; a[1] = bus.req_addr_1; d[1] = bus.req_data_1;
                rr[0] = bus.rsp_ready_0; rr[1] = bus.rsp_ready_1;
                r[0] = bus.req_ready_0; r[1] = bus.req_ready_1;
                rv[0] = bus.rsp_valid_0; rv[1] = bus.rsp_valid_1;
                rd[0] = bus.rsp_data_0; rd[1] = bus.rsp_data_1;
                ce[0] = bus.CE0; ce[1] = bus.CE1; weo[0] = bus.WE0; weo[1] = bus.WE1;
                ao[0] = bus.A0; ao[1] = bus.A1;

                coll = v[0] && v[1] && (a[0] == a[1]) && (we[0] || we[1]);
                for (int c = 0; c < 2; c++) begin
                    exp_r[c] = we[c] ? 1'b1 : (exp_q[c].size() < 2);
                    if (c == 1 && coll) exp_r[c] = 1'b0;
                    exp_rv[c] = (exp_q[c].size() > 0) && (exp_q[c][0].cyc < cyc_n);
                    chk($sformatf("rnd%0d_ready%0d", n, c), r[c], exp_r[c]);
                    chk($sformatf("rnd%0d_rsp_valid%0d", n, c), rv[c], exp_rv[c]);
                    if (exp_rv[c] && rr[c]) begin
                        chk($sformatf("rnd%0d_rsp_data%0d", n, c), rd[c], exp_q[c][0].data);
                        void'(exp_q[c].pop_front());
                    end
                    if (v[c] && exp_r[c]) begin
                        chk($sformatf("rnd%0d_port%0d", n, c), {ce[c], weo[c], ao[c]}, {1'b1, we[c], a[c]});
                        if (!we[c]) exp_q[c].push_back('{refmem[a[c]], cyc_n});
                    end
                end
                for (int c = 0; c < 2; c++)
                    if (v[c] && exp_r[c] && we[c]) refmem[a[c]] = d[c];
                cyc_n++;
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
